mul_job_sched: RTL and testbench
================================

// Module: mul_job_sched
// PURPOSE
//  Sequencer and arbiter for the shift-free repeated-addition MUL datapath (A, B, P registers, eqz flag).
//  Shares one datapath between N_REQ requesters with round-robin arbitration.
//  Drives the load/clear/decrement strobes and returns tagged products through a valid/ready response port.
//  Replaces the single-user start/done controller wherever the datapath is shared.
// PARAMETERS
//  N_REQ  4   number of requesters (2..8)
//  W      16  operand, bus and product width; product is truncated mod 2^W
//  ID_W   2   width of the requester index; equals $clog2(N_REQ)
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous active-low reset
//  req         in   N_REQ     per-requester job request; held until the matching ack
//  req_a       in   N_REQ*W   operand A, slice i belongs to requester i
//  req_b       in   N_REQ*W   operand B (repeat count), slice i
//  ack         out  N_REQ     one-hot, 1-cycle pulse when requester i's operands are captured
//  resp_valid  out  1         result available
//  resp_ready  in   1         consumer accepts the result
//  resp_id     out  ID_W      index of the requester that owns the result
//  resp_prod   out  W         product A*B mod 2^W
//  busy        out  1         high in any state other than IDLE
//  dp_bus      out  W         datapath data_in
//  ld_a        out  1         datapath load A
//  ld_b        out  1         datapath load B
//  clr_p       out  1         datapath clear P
//  ld_p        out  1         datapath load P (P <= P + A)
//  dec_b       out  1         datapath decrement B
//  eqz         in   1         datapath flag: B == 0 (combinational from the B register)
//  dp_prod     in   W         datapath P register
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, every output 0, internal operand/id/result registers 0.
//  Reset mid-job abandons the job with no response. Datapath register contents are don't-care; the next job reloads them.
//  FSM, one state per cycle unless noted:
//   IDLE: if |req: grant = first set bit at or above rr_ptr (wrapping).
//         Latch a_q, b_q, id_q; pulse ack[grant]; rr_ptr <= grant+1 mod N_REQ; go LDA. Else stay.
//   LDA: dp_bus=a_q, ld_a=1 -> LDB.
//   LDB: dp_bus=b_q, ld_b=1, clr_p=1 -> ACC.
//   ACC: if eqz: prod_q <= dp_prod -> RESP; else ld_p=1, dec_b=1, stay.
//   RESP: resp_valid=1, resp_id=id_q, resp_prod=prod_q. Held stable until resp_ready; on valid&ready -> IDLE.
//  Strobes are Moore outputs, mutually exclusive except the pairs ld_b+clr_p and ld_p+dec_b. dp_bus=0 outside LDA/LDB.
//  Latency: ack at cycle 0 -> resp_valid at cycle 4+B. B=0 gives 4 cycles and product 0.
//  A request deasserted before its ack is ignored. Requesters not granted keep waiting; no starvation (round-robin).
//  Back-pressure: while in RESP no new job is accepted, so req may wait indefinitely.
//  Overflow: wraps mod 2^W, matching the datapath adder; no flag.
//  X on req of a non-granted requester must not affect the outputs.
// CONFIGURATION
//  MUL_ZERO_BYPASS_EN defined: in IDLE, if the granted A==0 or B==0, prod_q<=0 and go straight to RESP.
//   Response follows at cycle 1; no datapath strobes fire; ack and rr_ptr update unchanged.
//  Undefined: zero operands take the full LDA/LDB/ACC path (cycle 4 for B=0).
// STRUCTURE
//  Package mul_sched_pkg: state enum {IDLE,LDA,LDB,ACC,RESP}, localparam defaults for N_REQ/W, function rr_pick().
//  One sub-module: mul_rr_arb (combinational round-robin picker: req, rr_ptr -> one-hot grant + index).
//  The FSM, operand capture and response register stay in mul_job_sched.
// TESTING (bench instantiates the real MUL datapath)
//  T1 single: req[0], A=7, B=5 -> ack[0] at c0; resp_valid at c9; resp_id=0, resp_prod=35; exactly 5 ld_p pulses.
//  T2 zero: A=9, B=0 -> resp_prod=0 at c4 (c1 with MUL_ZERO_BYPASS_EN, and no strobes).
//  T3 round-robin: req=4'b1111 held, B=1 each -> grant order 0,1,2,3,0; products correct per id.
//  T4 back-pressure: resp_ready=0 for 10 cycles -> resp_valid, resp_id and resp_prod stable; no ack while waiting.
//  T5 reset mid-ACC: rst_n low at c5 of an A=3, B=8 job -> outputs 0 immediately; idle; next job 2*3 -> 6.
//  T6 overflow (W=16): A=16'hFFFF, B=2 -> resp_prod=16'hFFFE.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and helpers for the MUL job scheduler.
// Holds the FSM state enum, default sizes and the round-robin pick function.
package mul_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        LDB,
        ACC,
        RESP
    } state_t;

    // First set bit at or above ptr, wrapping within n requesters.
    // Callers pad req/ptr to 8/3 bits so one function covers N_REQ 2..8.
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  req,
        input logic [2:0]  ptr,
        input int unsigned n
    );
        logic [2:0]  idx;
        logic        found;
        int unsigned j;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            j = (32'(ptr) + k) % n;
            if (k < n && !found && req[j[2:0]]) begin
                idx   = j[2:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mul_rr_arb.sv
// mul_rr_arb: combinational round-robin picker for the MUL scheduler.
// Ports: i_req (requests), i_ptr (priority start) -> o_gnt one-hot, o_idx, o_any.
module mul_rr_arb
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [7:0] w_req8;
    logic [2:0] w_ptr3;
    logic [2:0] w_pick;

    always_comb begin
        w_req8               = '0;
        w_req8[N_REQ-1:0]    = i_req;
        w_ptr3               = '0;
        w_ptr3[ID_W-1:0]     = i_ptr;
        w_pick               = rr_pick(w_req8, w_ptr3, N_REQ);
        o_any                = |i_req;
        o_idx                = w_pick[ID_W-1:0];
        o_gnt                = '0;
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_job_sched.sv
// mul_job_sched: shares one repeated-addition MUL datapath between N_REQ
// requesters with round-robin arbitration and a valid/ready result port.
// Ports: req/req_a/req_b/ack (requesters), resp_* (results), busy,
// dp_bus/ld_a/ld_b/clr_p/ld_p/dec_b (datapath strobes), eqz/dp_prod (flags).
// Option: MUL_ZERO_BYPASS_EN answers A==0 or B==0 jobs directly from IDLE.
module mul_job_sched
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   ack,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic [W-1:0]       resp_prod,
    output logic               busy,
    output logic [W-1:0]       dp_bus,
    output logic               ld_a,
    output logic               ld_b,
    output logic               clr_p,
    output logic               ld_p,
    output logic               dec_b,
    input  logic               eqz,
    input  logic [W-1:0]       dp_prod
);

    state_t          r_state;
    state_t          w_state_nx;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_prod;

    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic             w_any;
    logic             w_take;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
`ifdef MUL_ZERO_BYPASS_EN
    logic             w_zero;
`endif

    mul_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Only the granted slice is read, so other requesters' operands
    // cannot disturb the capture.
    always_comb begin
        w_a    = req_a[w_idx*W +: W];
        w_b    = req_b[w_idx*W +: W];
        w_take = (r_state == IDLE) && w_any;
`ifdef MUL_ZERO_BYPASS_EN
        w_zero = (w_a == '0) || (w_b == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else begin
            if (w_take) begin
                r_a   <= w_a;
                r_b   <= w_b;
                r_id  <= w_idx;
                r_ptr <= (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
                if (w_zero) begin
                    r_prod <= '0;
                end
`endif
            end
            if (r_state == ACC && eqz) begin
                r_prod <= dp_prod;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        ack        = '0;
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_prod  = '0;
        busy       = (r_state != IDLE);
        dp_bus     = '0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        clr_p      = 1'b0;
        ld_p       = 1'b0;
        dec_b      = 1'b0;
        unique case (r_state)
            IDLE: begin
                // ack is combinational from req; hold it low in reset.
                if (rst_n) begin
                    ack = w_gnt;
                end
                if (w_any) begin
                    w_state_nx = LDA;
`ifdef MUL_ZERO_BYPASS_EN
                    if (w_zero) begin
                        w_state_nx = RESP;
                    end
`endif
                end
            end
            LDA: begin
                dp_bus     = r_a;
                ld_a       = 1'b1;
                w_state_nx = LDB;
            end
            LDB: begin
                dp_bus     = r_b;
                ld_b       = 1'b1;
                clr_p      = 1'b1;
                w_state_nx = ACC;
            end
            ACC: begin
                if (eqz) begin
                    w_state_nx = RESP;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_id    = r_id;
                resp_prod  = r_prod;
                if (resp_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_job_sched.sv
// tb_mul_job_sched: random and directed jobs against a behavioural model,
// with a datapath model, a scoreboard queue and a negedge monitor.
module tb_mul_job_sched;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     ack;
    logic             resp_valid;
    logic             resp_ready;
    logic [IW-1:0]    resp_id;
    logic [W-1:0]     resp_prod;
    logic             busy;
    logic [W-1:0]     dp_bus;
    logic             ld_a, ld_b, clr_p, ld_p, dec_b;
    logic             eqz;
    logic [W-1:0]     dp_prod;

    always #5 clk = ~clk;

    mul_job_sched #(.N_REQ(N), .W(W), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .ack        (ack),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_prod  (resp_prod),
        .busy       (busy),
        .dp_bus     (dp_bus),
        .ld_a       (ld_a),
        .ld_b       (ld_b),
        .clr_p      (clr_p),
        .ld_p       (ld_p),
        .dec_b      (dec_b),
        .eqz        (eqz),
        .dp_prod    (dp_prod)
    );

    // Repeated-addition datapath: A, B, P registers and eqz flag.
    logic [W-1:0] dA = '0;
    logic [W-1:0] dB = '0;
    logic [W-1:0] dP = '0;
    assign eqz     = (dB == '0);
    assign dp_prod = dP;

    always @(posedge clk) begin
        if (ld_a) dA <= dp_bus;
        if (ld_b) dB <= dp_bus;
        else if (dec_b) dB <= dB - 1'b1;
        if (clr_p) dP <= '0;
        else if (ld_p) dP <= dP + dA;
    end

    typedef struct {
        logic [IW-1:0] id;
        logic [W-1:0]  prod;
        int            t_ack;
        int            lat;
        int            nldp;
        int            nst;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] ra[N];
    logic [W-1:0] rb[N];
    int           ack_cnt[N];
    int           errs = 0;
    int           checks = 0;
    int           cyc = 0;
    int           mptr = 0;
    bit           inflight = 1'b0;
    bit           seen_valid = 1'b0;
    int           ldp_cnt = 0;
    int           st_cnt = 0;
    bit           fin_req = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [4:0]   s;
        int           g;
        exp_t         e;
        logic [N-1:0] exp_ack;
        cyc++;
        if (cyc > 40000) begin
            $display("FAIL watchdog: cycle budget exhausted");
            $fatal(1);
        end
        if (!rst_n) begin
            chk("reset_outputs",
                64'({ack, resp_valid, resp_id, resp_prod, busy, dp_bus,
                     ld_a, ld_b, clr_p, ld_p, dec_b}), 64'(0));
            q.delete();
            inflight   = 1'b0;
            seen_valid = 1'b0;
            mptr       = 0;
        end else begin
            s = {ld_a, ld_b, clr_p, ld_p, dec_b};
            chk("strobe_pairs",
                64'(s inside {5'b00000, 5'b10000, 5'b01100, 5'b00011}),
                64'(1));
            if (!(ld_a || ld_b)) chk("bus_idle", 64'(dp_bus), 64'(0));
            chk("busy", 64'(busy), 64'(inflight));
            if (ld_p) ldp_cnt++;
            if (s != 5'b0) st_cnt++;
            if (inflight) begin
                chk("no_ack_while_busy", 64'(ack), 64'(0));
            end else begin
                g = rr_model(req, mptr);
                exp_ack = '0;
                if (g >= 0) exp_ack[g] = 1'b1;
                chk("ack_grant", 64'(ack), 64'(exp_ack));
                if (g >= 0) begin
                    e.id    = IW'(g);
                    e.prod  = ra[g] * rb[g];
                    e.t_ack = cyc;
                    e.lat   = 4 + int'(rb[g]);
                    e.nldp  = int'(rb[g]);
                    e.nst   = 2 + int'(rb[g]);
`ifdef MUL_ZERO_BYPASS_EN
                    if (ra[g] == '0 || rb[g] == '0) begin
                        e.lat  = 1;
                        e.nldp = 0;
                        e.nst  = 0;
                    end
`endif
                    q.push_back(e);
                    ack_cnt[g]++;
                    mptr       = (g + 1) % N;
                    inflight   = 1'b1;
                    seen_valid = 1'b0;
                    ldp_cnt    = 0;
                    st_cnt     = 0;
                end
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL resp_unexpected at cycle %0d: got id %0d prod %0h expected no response",
                             cyc, resp_id, resp_prod);
                end else begin
                    chk("resp_id", 64'(resp_id), 64'(q[0].id));
                    chk("resp_prod", 64'(resp_prod), 64'(q[0].prod));
                    if (!seen_valid) begin
                        chk("latency", 64'(cyc - q[0].t_ack), 64'(q[0].lat));
                        chk("ld_p_pulses", 64'(ldp_cnt), 64'(q[0].nldp));
                        chk("strobe_cycles", 64'(st_cnt), 64'(q[0].nst));
                        seen_valid = 1'b1;
                    end
                    if (resp_ready) begin
                        void'(q.pop_front());
                        inflight   = 1'b0;
                        seen_valid = 1'b0;
                    end
                end
            end
        end
        if (fin_req) begin
            chk("drain", 64'({q.size() == 0, req == '0, inflight}),
                64'(3'b110));
            $display("Result: errors=%0d of %0d checks", errs, checks);
            $finish;
        end
    end

    // Driver
    int seen[N];

    task automatic step();
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (req[i] && ack_cnt[i] != seen[i]) req[i] = 1'b0;
            seen[i] = ack_cnt[i];
        end
    endtask

    task automatic issue(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        ra[i]            = a;
        rb[i]            = b;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req[i]           = 1'b1;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((req != '0 || q.size() != 0 || inflight) && n < maxc) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        req        = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            seen[i] = 0;
            ack_cnt[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        issue(0, 16'd7, 16'd5);
        wait_idle(100);
        issue(1, 16'd9, 16'd0);
        wait_idle(100);
        issue(2, 16'hFFFF, 16'd2);
        wait_idle(100);

        for (int i = 0; i < N; i++) issue(i, W'(i + 3), 16'd1);
        n = 0;
        while (req[0] && n < 100) begin
            step();
            n++;
        end
        issue(0, 16'd11, 16'd1);
        wait_idle(200);

        resp_ready = 1'b0;
        issue(3, 16'd5, 16'd6);
        issue(1, 16'd4, 16'd4);
        repeat (25) step();
        resp_ready = 1'b1;
        wait_idle(200);

        issue(1, 16'd3, 16'd8);
        n = 0;
        while (req[1] && n < 20) begin
            step();
            n++;
        end
        repeat (4) step();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        issue(2, 16'd2, 16'd3);
        wait_idle(100);

        repeat (500) begin
            resp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 5) == 0) begin
                    issue(i,
                          (($urandom % 6) == 0) ? '0 : W'($urandom),
                          W'($urandom % 11));
                end
            end
            step();
        end

        resp_ready = 1'b1;
        wait_idle(3000);
        fin_req = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL finish: monitor did not end the run");
        $fatal(1);
    end

endmodule
